// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - debounced push-button entry of A, B and function code for the ALU.
// A single key press commits the slide switches into the register selected by the entry FSM.
module alu_operand_loader #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             key_n,
  output logic [WIDTH-1:0] ain,
  output logic [WIDTH-1:0] bin,
  output logic             fun_sel0,
  output logic             fun_sel1,
  output logic             operand_valid,
  output logic [1:0]       entry_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'b00,
    LOAD_B  = 2'b01,
    LOAD_OP = 2'b10,
    SHOW    = 2'b11
  } state_t;

  state_t        state, state_nxt;
  logic          sync1, key_s;
  logic          deb, deb_d;
  logic [CW-1:0] cnt;
  logic          press;
  logic          load_a, load_b, load_op, clr_valid;

  // Two-flop synchronizer, idle-high so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      key_s <= 1'b1;
    end else begin
      sync1 <= key_n;
      key_s <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb <= 1'b1;
      cnt <= '0;
    end else if (key_s == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      deb <= key_s;
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Registered falling-edge detect of the debounced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_d <= 1'b1;
      press <= 1'b0;
    end else begin
      deb_d <= deb;
      press <= deb_d & ~deb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD_A;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (press) begin
      case (state)
        LOAD_A:  state_nxt = LOAD_B;
        LOAD_B:  state_nxt = LOAD_OP;
        LOAD_OP: state_nxt = SHOW;
        SHOW:    state_nxt = LOAD_A;
        default: state_nxt = LOAD_A;
      endcase
    end
  end

  always_comb begin
    load_a    = 1'b0;
    load_b    = 1'b0;
    load_op   = 1'b0;
    clr_valid = 1'b0;
    if (press) begin
      case (state)
        LOAD_A:  load_a    = 1'b1;
        LOAD_B:  load_b    = 1'b1;
        LOAD_OP: load_op   = 1'b1;
        SHOW:    clr_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // Operand registers hold until explicitly overwritten, so SHOW keeps the ALU result on display.
  always_ff @(posedge clk) begin
    if (rst) begin
      ain           <= '0;
      bin           <= '0;
      fun_sel0      <= 1'b0;
      fun_sel1      <= 1'b0;
      operand_valid <= 1'b0;
    end else begin
      if (load_a) ain <= sw;
      if (load_b) bin <= sw;
      if (load_op) begin
        fun_sel0      <= sw[0];
        fun_sel1      <= sw[1];
        operand_valid <= 1'b1;
      end else if (clr_valid) begin
        operand_valid <= 1'b0;
      end
    end
  end

  assign entry_state = state;

endmodule
